// File: rtl/gmii_rx_decoder_if.sv
// -----------------------------------------------------------------------------
// gmii_rx_decoder_if
//   Bundles the raw GMII receive pins and the decoded byte stream of
//   gmii_rx_decoder.
//
//   PHY side      : rxd[7:0], rxdv, rxer
//   Stream side   : do_byte[7:0], do_vld, sop, eop
//   Frame status  : stat_crc_err, stat_rx_err, stat_len_err, stat_len[15:0]
//                   (meaningful only while eop=1, zero otherwise)
//   Housekeeping  : drop_cnt[15:0], frames aborted in preamble (saturating)
//
//   master : the decoder (consumes PHY pins, drives the stream)
//   slave  : the PHY/IBUF environment (drives PHY pins, consumes the stream)
// -----------------------------------------------------------------------------
interface gmii_rx_decoder_if;
    logic [7:0]  rxd;
    logic        rxdv;
    logic        rxer;

    logic [7:0]  do_byte;
    logic        do_vld;
    logic        sop;
    logic        eop;
    logic        stat_crc_err;
    logic        stat_rx_err;
    logic        stat_len_err;
    logic [15:0] stat_len;
    logic [15:0] drop_cnt;

    modport master (
        input  rxd, rxdv, rxer,
        output do_byte, do_vld, sop, eop,
        output stat_crc_err, stat_rx_err, stat_len_err, stat_len, drop_cnt
    );

    modport slave (
        output rxd, rxdv, rxer,
        input  do_byte, do_vld, sop, eop,
        input  stat_crc_err, stat_rx_err, stat_len_err, stat_len, drop_cnt
    );
endinterface

// File: rtl/gmii_rx_decoder.sv
// -----------------------------------------------------------------------------
// gmii_rx_decoder
//   Receive-side GMII front end. Registers the PHY pins once, finds and strips
//   preamble/SFD, and emits the frame bytes (FCS included) with SOP/EOP/valid.
//   CRC-32 and frame length are tracked on the fly; a status word is presented
//   together with the last byte so the downstream IBUF can keep or discard it.
//
//   Ports
//     clk      : GMII receive clock (125 MHz)
//     rst      : asynchronous, active-high reset
//     io       : gmii_rx_decoder_if.master (PHY pins in, byte stream and
//                status out, drop counter out)
//
//   Timing: a byte on rxd in cycle n is on do_byte in cycle n+2. Each byte is
//   held one cycle so the decoder can tell, from the next registered rxdv,
//   whether it is the last one; eop and the status word are therefore decoded
//   from the hold register and the input stage register.
// -----------------------------------------------------------------------------
module gmii_rx_decoder #(
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1518,
    parameter int MIN_PREAMBLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    gmii_rx_decoder_if.master io
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;  // 0x04C11DB7 reflected
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [2:0]  PRE_CNT_MAX = 3'd7;

    // One byte of the reflected CRC-32, data consumed LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc,
                                             input logic [7:0]  d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Input stage
    logic [7:0]  s1_d;
    logic        s1_dv;
    logic        s1_er;

    // Decoder state
    state_t      state;
    logic [2:0]  pre_cnt;
    logic [31:0] crc_q;
    logic [15:0] len_q;
    logic        rx_err_q;
    logic [15:0] drop_cnt_q;

    // One-byte hold (output) stage
    logic [7:0]  hold_d;
    logic        hold_vld;
    logic        hold_sop;

    // NOTE: every register written here uses <=, so all of them see the
    // values from before the edge; mixing in = would make the result depend
    // on statement order inside the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_d       <= '0;
            s1_dv      <= 1'b0;
            s1_er      <= 1'b0;
            state      <= IDLE;
            pre_cnt    <= '0;
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            rx_err_q   <= 1'b0;
            drop_cnt_q <= '0;
            hold_d     <= '0;
            hold_vld   <= 1'b0;
            hold_sop   <= 1'b0;
        end else begin
            s1_d  <= io.rxd;
            s1_dv <= io.rxdv;
            s1_er <= io.rxer;

            case (state)
                IDLE: begin
                    if (s1_dv) begin
                        if (s1_d == PRE_BYTE) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state      <= DROP;
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                        end
                    end
                end

                PREAMBLE: begin
                    if (!s1_dv) begin
                        state      <= IDLE;
                        drop_cnt_q <= sat_inc(drop_cnt_q);
                    end else if (s1_er) begin
                        state      <= DROP;
                        drop_cnt_q <= sat_inc(drop_cnt_q);
                    end else if (s1_d == PRE_BYTE) begin
                        if (pre_cnt != PRE_CNT_MAX) begin
                            pre_cnt <= pre_cnt + 3'd1;
                        end
                    end else if (s1_d == SFD_BYTE &&
                                 32'(pre_cnt) >= MIN_PREAMBLE) begin
                        // Per-frame accumulators restart at SFD.
                        state    <= DATA;
                        crc_q    <= CRC_INIT;
                        len_q    <= '0;
                        rx_err_q <= 1'b0;
                    end else begin
                        state      <= DROP;
                        drop_cnt_q <= sat_inc(drop_cnt_q);
                    end
                end

                DATA: begin
                    if (s1_dv) begin
                        crc_q    <= crc_next(crc_q, s1_d);
                        len_q    <= sat_inc(len_q);
                        rx_err_q <= rx_err_q | s1_er;
                        hold_d   <= s1_d;
                        hold_vld <= 1'b1;
                        // len_q saturates, so it is zero only before byte 1.
                        hold_sop <= (len_q == 16'd0);
                    end else begin
                        // The held byte goes out with eop this cycle.
                        state    <= IDLE;
                        hold_vld <= 1'b0;
                        hold_sop <= 1'b0;
                    end
                end

                DROP: begin
                    if (!s1_dv) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // hold_vld is only ever set in DATA, so a held byte with rxdv low at the
    // input stage is exactly the last byte of the frame. The CRC and length
    // already include that byte.
    logic        last_byte;
    logic [31:0] crc_rev;

    assign last_byte = hold_vld & ~s1_dv;
    // The residue is quoted in non-reflected bit order.
    assign crc_rev   = {<<{crc_q}};

    assign io.do_byte      = hold_vld ? hold_d : 8'h00;
    assign io.do_vld       = hold_vld;
    assign io.sop          = hold_vld & hold_sop;
    assign io.eop          = last_byte;
    assign io.stat_crc_err = last_byte & (crc_rev != CRC_RESIDUE);
    assign io.stat_rx_err  = last_byte & rx_err_q;
    assign io.stat_len_err = last_byte & ((32'(len_q) < MIN_LEN) ||
                                          (32'(len_q) > MAX_LEN));
    assign io.stat_len     = last_byte ? len_q : 16'h0000;
    assign io.drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_gmii_rx_decoder
//   Directed + randomized bench for gmii_rx_decoder. Frames are built with a
//   random payload and a standard Ethernet FCS; expected output is derived at
//   frame level (byte list, SOP/EOP position, latency, status fields).
// -----------------------------------------------------------------------------
module tb_gmii_rx_decoder;

    logic clk;
    logic rst;
    int   cyc;
    int   n_total;
    int   n_passed;

    gmii_rx_decoder_if io ();

    gmii_rx_decoder #(
        .MIN_LEN      (64),
        .MAX_LEN      (1518),
        .MIN_PREAMBLE (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.master)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Everything the DUT emits is recorded for later frame-level comparison.
    typedef struct {
        logic [7:0]  d;
        logic        sop;
        logic        eop;
        logic        crc_err;
        logic        rx_err;
        logic        len_err;
        logic [15:0] len;
        int          cyc;
    } obs_t;

    obs_t obs_q[$];

    always @(negedge clk) begin
        obs_t o;
        if (rst === 1'b0 && io.do_vld === 1'b1) begin
            o.d       = io.do_byte;
            o.sop     = io.sop;
            o.eop     = io.eop;
            o.crc_err = io.stat_crc_err;
            o.rx_err  = io.stat_rx_err;
            o.len_err = io.stat_len_err;
            o.len     = io.stat_len;
            o.cyc     = cyc;
            obs_q.push_back(o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Standard Ethernet FCS (reflected CRC-32, final inversion), byte-wise.
    function automatic logic [31:0] fcs_of(input logic [7:0] q[$], input int cnt);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < cnt; i++) begin
            c = c ^ 32'(q[i]);
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    logic [7:0] frm[$];
    logic [7:0] frm_a[$];

    task automatic make_frame(input int n);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom));
        fcs = fcs_of(frm, n - 4);
        for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
    endtask

    task automatic step(input logic [7:0] d, input logic dv, input logic er);
        io.rxd  = d;
        io.rxdv = dv;
        io.rxer = er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int pre_len, input int err_idx,
                              output int first_cyc);
        for (int i = 0; i < pre_len; i++) step(8'h55, 1'b1, 1'b0);
        step(8'hD5, 1'b1, 1'b0);
        first_cyc = cyc;
        for (int i = 0; i < frm.size(); i++) step(frm[i], 1'b1, 1'(i == err_idx));
        step(8'h00, 1'b0, 1'b0);
    endtask

    // Frame-level expectation: every byte in order, SOP on the first, EOP on
    // the last, two-cycle latency, status only on EOP.
    task automatic check_frame(input string name, input logic [7:0] f[$],
                               input int first_cyc, input logic exp_rx);
        int          n;
        int          got;
        int          bad_d;
        int          bad_sop;
        int          bad_eop;
        int          bad_mid;
        int          first_o;
        obs_t        o;
        obs_t        last;
        logic [31:0] fcs_field;
        logic        exp_crc;
        logic        exp_len_err;
        logic [15:0] exp_len;

        n         = f.size();
        bad_d     = 0;
        bad_sop   = 0;
        bad_eop   = 0;
        bad_mid   = 0;
        first_o   = -1;
        last      = '{default: 'x};
        fcs_field = {f[n-1], f[n-2], f[n-3], f[n-4]};
        exp_crc   = (fcs_of(f, n - 4) != fcs_field);
        exp_len   = (n > 65535) ? 16'hFFFF : 16'(n);
        exp_len_err = (n < 64) || (n > 1518);

        got = (obs_q.size() < n) ? obs_q.size() : n;
        check({name, " byte_count"}, 32'(got), 32'(n));
        for (int i = 0; i < got; i++) begin
            o = obs_q.pop_front();
            if (i == 0) first_o = o.cyc;
            if (o.d !== f[i]) bad_d++;
            if (o.sop !== 1'(i == 0)) bad_sop++;
            if (o.eop !== 1'(i == n - 1)) bad_eop++;
            if (i != n - 1 &&
                {o.crc_err, o.rx_err, o.len_err, o.len} !== 19'd0) bad_mid++;
            last = o;
        end
        check({name, " data"},          32'(bad_d),   32'd0);
        check({name, " sop_pos"},       32'(bad_sop), 32'd0);
        check({name, " eop_pos"},       32'(bad_eop), 32'd0);
        check({name, " stat_mid_zero"}, 32'(bad_mid), 32'd0);
        check({name, " first_latency"}, 32'(first_o), 32'(first_cyc + 2));
        check({name, " last_latency"},  32'(last.cyc), 32'(first_cyc + n + 1));
        check({name, " crc_err"},       32'(last.crc_err), 32'(exp_crc));
        check({name, " rx_err"},        32'(last.rx_err),  32'(exp_rx));
        check({name, " len_err"},       32'(last.len_err), 32'(exp_len_err));
        check({name, " len"},           32'(last.len),     32'(exp_len));
    endtask

    initial begin
        int fc;
        int fc_a;
        int eops;
        int n;
        int pre;
        int eidx;

        n_total  = 0;
        n_passed = 0;
        cyc      = 0;
        io.rxd   = 8'h00;
        io.rxdv  = 1'b0;
        io.rxer  = 1'b0;
        rst      = 1'b1;

        // Reset state
        #21;
        check("reset do_vld",   32'(io.do_vld),   32'd0);
        check("reset eop",      32'(io.eop),      32'd0);
        check("reset do_byte",  32'(io.do_byte),  32'd0);
        check("reset stat_len", 32'(io.stat_len), 32'd0);
        check("reset drop_cnt", 32'(io.drop_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(2);

        // Good 64-byte frame, full preamble
        make_frame(64);
        send_frame(7, -1, fc);
        idle(3);
        check_frame("good64", frm, fc, 1'b0);

        // Same frame with byte 20 corrupted
        frm[19] = frm[19] ^ 8'h01;
        send_frame(7, -1, fc);
        idle(3);
        check_frame("crc_bad64", frm, fc, 1'b0);

        // Preamble aborted by a bad byte, trailing bytes ignored
        step(8'h55, 1'b1, 1'b0);
        step(8'h55, 1'b1, 1'b0);
        step(8'h17, 1'b1, 1'b0);
        for (int i = 0; i < 70; i++) step(8'($urandom), 1'b1, 1'b0);
        idle(4);
        check("drop no_output", 32'(obs_q.size()), 32'd0);
        check("drop drop_cnt",  32'(io.drop_cnt),  32'd1);
        obs_q.delete();

        // Minimum preamble (one 0x55) and the drop counter holds
        make_frame(64);
        send_frame(1, -1, fc);
        idle(3);
        check_frame("min_pre64", frm, fc, 1'b0);
        check("after_drop drop_cnt", 32'(io.drop_cnt), 32'd1);

        // RXER inside the frame
        make_frame(100);
        send_frame(7, 49, fc);
        idle(3);
        check_frame("rxer100", frm, fc, 1'b1);

        // Length boundaries
        make_frame(63);
        send_frame(7, -1, fc);
        idle(3);
        check_frame("len63", frm, fc, 1'b0);

        make_frame(1518);
        send_frame(7, -1, fc);
        idle(3);
        check_frame("len1518", frm, fc, 1'b0);

        make_frame(1519);
        send_frame(7, -1, fc);
        idle(3);
        check_frame("len1519", frm, fc, 1'b0);

        // SFD immediately followed by RXDV low: nothing out, not a drop
        for (int i = 0; i < 7; i++) step(8'h55, 1'b1, 1'b0);
        step(8'hD5, 1'b1, 1'b0);
        idle(4);
        check("empty no_output", 32'(obs_q.size()), 32'd0);
        check("empty drop_cnt",  32'(io.drop_cnt),  32'd1);

        // Back-to-back frames with a single idle cycle between them
        make_frame(64);
        frm_a = frm;
        send_frame(7, -1, fc_a);
        make_frame(64);
        send_frame(7, -1, fc);
        idle(3);
        check_frame("b2b_first",  frm_a, fc_a, 1'b0);
        check_frame("b2b_second", frm,   fc,   1'b0);

        // Reset at byte 30 of a frame
        make_frame(64);
        for (int i = 0; i < 7; i++) step(8'h55, 1'b1, 1'b0);
        step(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 29; i++) step(frm[i], 1'b1, 1'b0);
        io.rxd  = frm[29];
        io.rxdv = 1'b1;
        io.rxer = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst do_vld",   32'(io.do_vld),   32'd0);
        check("midrst eop",      32'(io.eop),      32'd0);
        check("midrst sop",      32'(io.sop),      32'd0);
        check("midrst do_byte",  32'(io.do_byte),  32'd0);
        check("midrst drop_cnt", 32'(io.drop_cnt), 32'd0);
        io.rxdv = 1'b0;
        io.rxd  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        eops = 0;
        foreach (obs_q[i]) if (obs_q[i].eop === 1'b1) eops++;
        check("midrst no_eop", 32'(eops), 32'd0);
        obs_q.delete();

        make_frame(64);
        send_frame(7, -1, fc);
        idle(3);
        check_frame("post_rst64", frm, fc, 1'b0);
        check("post_rst drop_cnt", 32'(io.drop_cnt), 32'd0);

        // Randomized frames: length, preamble, optional bit flip and RXER
        for (int t = 0; t < 6; t++) begin
            n    = $urandom_range(60, 200);
            pre  = $urandom_range(1, 7);
            make_frame(n);
            if ($urandom_range(0, 1) == 1) begin
                int idx;
                idx = $urandom_range(0, n - 1);
                frm[idx] = frm[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
            eidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            send_frame(pre, eidx, fc);
            idle(3);
            check_frame($sformatf("rand%0d", t), frm, fc, 1'(eidx >= 0));
        end
        check("rand drop_cnt", 32'(io.drop_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/gmii_rx_decoder.md
Name: gmii_rx_decoder

Overview:
Receive-side GMII front end that sits directly upstream of the GMII input buffer (IBUF). It consumes raw PHY signals (RXD/RXDV/RXER), detects and strips preamble/SFD, and emits a byte stream with start-of-packet, end-of-packet and valid flags. It checks CRC-32 and frame length on the fly and presents a per-frame status word with the last byte, which the IBUF uses to accept or discard the frame.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (destination MAC through FCS inclusive)
MAX_LEN, 1518, maximum legal frame length in bytes (destination MAC through FCS inclusive)
MIN_PREAMBLE, 1, minimum number of 0x55 bytes required before SFD

Ports:
CLK  in  1  GMII receive clock, 125 MHz
RESET  in  1  asynchronous active-high reset
RXD  in  8  GMII receive data
RXDV  in  1  GMII receive data valid
RXER  in  1  GMII receive error
DO  out  8  frame byte; FCS bytes included
DO_VLD  out  1  DO carries a frame byte this cycle
SOP  out  1  first frame byte (qualified by DO_VLD)
EOP  out  1  last frame byte (qualified by DO_VLD); STAT_* valid only this cycle
STAT_CRC_ERR  out  1  CRC residue mismatch
STAT_RX_ERR  out  1  RXER seen during frame data
STAT_LEN_ERR  out  1  length < MIN_LEN or > MAX_LEN
STAT_LEN  out  16  frame length in bytes, saturating at 0xFFFF
DROP_CNT  out  16  count of frames aborted in preamble, saturating

Behaviour:
- Clocking and reset
  - Single clock CLK; RESET is asynchronous and active-high.
  - During reset all outputs are 0, the FSM is in IDLE, the CRC register is 0xFFFFFFFF, the length counter is 0 and DROP_CNT is 0.
- Input stage: RXD/RXDV/RXER are registered once (stage S1). All decoding uses S1 values.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: RXDV=1 and RXD=0x55 -> PREAMBLE, preamble count=1. RXDV=1 with any other byte -> DROP, DROP_CNT+1.
  - PREAMBLE:
    - 0x55 -> stay, count +1 (the count saturates at 7).
    - 0xD5 with count >= MIN_PREAMBLE -> DATA.
    - 0xD5 with count < MIN_PREAMBLE, any other byte, or RXER=1 -> DROP, DROP_CNT+1.
    - RXDV=0 -> IDLE, DROP_CNT+1.
  - DATA:
    - RXDV=1: byte accepted; CRC updated (reflected poly 0x04C11DB7, LSB first); length +1; RXER=1 sets the sticky rx_err flag.
    - RXDV=0: frame ends -> IDLE.
  - DROP: wait for RXDV=0 -> IDLE. No output is produced.
- Output stage (one-byte hold)
  - Each accepted byte is held in a register and released when the next S1 cycle is known.
  - If the next cycle is also a DATA byte, the held byte is output with EOP=0.
  - If RXDV has fallen, the held byte is output with EOP=1.
  - Latency: the byte on RXD in cycle n appears on DO in cycle n+2. EOP for the last byte is asserted in the cycle after RXDV falls at S1.
- SOP is 1 on the first DO_VLD byte after SFD.
- A frame with zero data bytes (RXDV falls right after SFD) produces no output and does not increment DROP_CNT.
- Status, valid only with EOP:
  - CRC check: the running CRC over all bytes including FCS equals residue 0xC704DD7B -> STAT_CRC_ERR=0, otherwise 1.
  - STAT_LEN = bytes after SFD, up to and including the last byte.
  - STAT_LEN_ERR = (STAT_LEN < MIN_LEN) or (STAT_LEN > MAX_LEN).
  - STAT_RX_ERR = sticky rx_err flag.
  - All STAT_* outputs are 0 when EOP=0.
- Frame boundaries
  - The CRC, length and rx_err registers re-initialise at SFD detection.
  - Minimum interframe gap is 1 cycle of RXDV=0. Back-to-back frames must decode correctly; the EOP of frame k precedes the SOP of frame k+1.
- Reset mid-frame: output clears asynchronously with no EOP emitted. The next frame after reset deassertion decodes normally.
- No backpressure: the downstream block must accept one byte per cycle.

Test Plan:
- Preamble 7x0x55 + 0xD5, then a 64-byte frame with valid FCS -> 64 DO_VLD cycles, SOP on byte 1, EOP on byte 64 at RXD-to-DO latency 2, STAT_LEN=64, CRC/RX/LEN errors all 0.
- Same frame with byte 20 XORed with 0x01 -> EOP with STAT_CRC_ERR=1, STAT_LEN=64.
- Preamble 0x55,0x55,0x17 then 70 bytes -> no DO_VLD, DROP_CNT=1; a following good frame decodes with DROP_CNT still 1.
- Good 100-byte frame with RXER=1 on byte 50 -> all 100 bytes output, STAT_RX_ERR=1. 63-byte good-CRC frame -> STAT_LEN_ERR=1. 1519-byte frame -> STAT_LEN_ERR=1.
- Two good 64-byte frames separated by one RXDV=0 cycle -> two complete SOP..EOP sequences, both error-free.
- RESET pulsed at byte 30 of a frame -> all outputs 0 immediately, no EOP; the next good frame decodes with STAT_LEN=64 and DROP_CNT=0.
